// File: rtl/tile_assembler.sv
// tile_assembler: ping-pong buffer that gathers a raster pixel stream into WIDTH x WIDTH tiles
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   pix_in/pix_valid/pix_last/pix_ready   pixel input handshake (pix_last only checked)
//   tile_out/tile_valid/tile_ready        flat row-major tile output handshake
//   frame_err               sticky flag: pix_last disagreed with the pixel count
//   tiles_done              tiles handed off, wrapping
module tile_assembler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [31:0]                      pix_in,
    input  logic                             pix_valid,
    input  logic                             pix_last,
    output logic                             pix_ready,
    output logic [WIDTH*WIDTH-1:0][31:0]     tile_out,
    output logic                             tile_valid,
    input  logic                             tile_ready,
    output logic                             frame_err,
    output logic [CNT_W-1:0]                 tiles_done
);
    localparam int N = WIDTH * WIDTH;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0][N-1:0][31:0] bank_q, bank_d;
    logic [1:0]              full_q, full_d;
    logic                    wr_sel_q, wr_sel_d;
    logic                    rd_sel_q, rd_sel_d;
    logic [IW-1:0]           cnt_q, cnt_d;
    logic                    frame_err_q, frame_err_d;
    logic [CNT_W-1:0]        tiles_done_q, tiles_done_d;
    logic                    accept, handoff, at_last;

    assign pix_ready  = !full_q[wr_sel_q];
    assign tile_valid = full_q[rd_sel_q];
    assign tile_out   = bank_q[rd_sel_q];
    assign frame_err  = frame_err_q;
    assign tiles_done = tiles_done_q;
    assign accept     = pix_valid && pix_ready;
    assign handoff    = tile_valid && tile_ready;
    assign at_last    = cnt_q == LAST;

    // A completing write and a handoff always target different banks: the write bank
    // is not full while the read bank is, so both full-flag updates can apply together.
    always_comb begin
        bank_d       = bank_q;
        full_d       = full_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        cnt_d        = cnt_q;
        frame_err_d  = frame_err_q;
        tiles_done_d = tiles_done_q;
        if (handoff) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            tiles_done_d     = tiles_done_q + 1'b1;
        end
        if (accept) begin
            bank_d[wr_sel_q][cnt_q] = pix_in;
            cnt_d                   = at_last ? '0 : cnt_q + 1'b1;
            frame_err_d             = frame_err_q || (pix_last != at_last);
            if (at_last) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q       <= '0;
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            cnt_q        <= '0;
            frame_err_q  <= 1'b0;
            tiles_done_q <= '0;
        end else begin
            bank_q       <= bank_d;
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            cnt_q        <= cnt_d;
            frame_err_q  <= frame_err_d;
            tiles_done_q <= tiles_done_d;
        end
    end
endmodule

// File: tb/tb_tile_assembler.sv
// tb_tile_assembler: randomized and directed checks of tile_assembler against a queue-based model
module tb_tile_assembler;
    localparam int W = 8;
    localparam int N = W * W;
    localparam int CW = 4;
    typedef logic [N*32-1:0] tile_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [31:0]          pix_in = '0;
    logic                 pix_valid = 1'b0;
    logic                 pix_last = 1'b0;
    logic                 pix_ready;
    logic [N-1:0][31:0]   tile_out;
    logic                 tile_valid;
    logic                 tile_ready = 1'b0;
    logic                 frame_err;
    logic [CW-1:0]        tiles_done;

    tile_assembler #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_ready(pix_ready), .tile_out(tile_out),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .frame_err(frame_err),
        .tiles_done(tiles_done)
    );

    always #5 clk = !clk;

    int passed = 0;
    int total = 0;

    logic [31:0] part[$];
    tile_t       pend[$];
    logic        m_err = 1'b0;
    logic [CW-1:0] m_done = '0;
    int          made = 0;
    logic        ready_seen_low = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [33:0] pool4(input logic [31:0] a, b, c, d);
        return ({2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d}) >> 2;
    endfunction

    // Compare one tile word (first mismatch, or word 0) and one pooled output likewise.
    task automatic check_tile(input string tag, input tile_t exp, input logic do_pool);
        int k = 0;
        for (int i = N - 1; i >= 0; i--) if (tile_out[i] !== exp[i*32 +: 32]) k = i;
        check(tag, {32'b0, tile_out[k]}, {32'b0, exp[k*32 +: 32]});
        if (do_pool) begin
            logic [33:0] g, e;
            int pk = 0;
            logic [33:0] g0 = '0, e0 = '0;
            for (int r = W / 2 - 1; r >= 0; r--)
                for (int c = W / 2 - 1; c >= 0; c--) begin
                    int a = 2 * c + 2 * r * W;
                    g = pool4(tile_out[a], tile_out[a+1], tile_out[a+W], tile_out[a+W+1]);
                    e = pool4(exp[a*32 +: 32], exp[(a+1)*32 +: 32],
                              exp[(a+W)*32 +: 32], exp[(a+W+1)*32 +: 32]);
                    if (g !== e || (r == 0 && c == 0 && pk == 0)) begin
                        pk = 1; g0 = g; e0 = e;
                    end
                end
            check("pool", {30'b0, g0}, {30'b0, e0});
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] p, input logic l, input logic tr);
        logic exp_rdy, exp_vld, acc, ho;
        tile_t t;
        pix_valid = v; pix_in = p; pix_last = l; tile_ready = tr;
        #1;
        exp_rdy = pend.size() < 2;
        exp_vld = pend.size() > 0;
        check("pix_ready", {63'b0, pix_ready}, {63'b0, exp_rdy});
        check("tile_valid", {63'b0, tile_valid}, {63'b0, exp_vld});
        check("frame_err", {63'b0, frame_err}, {63'b0, m_err});
        check("tiles_done", {60'b0, tiles_done}, {60'b0, m_done});
        acc = v && exp_rdy;
        ho = exp_vld && tr;
        if (!pix_ready) ready_seen_low = 1'b1;
        if (exp_vld) check_tile("tile_out", pend[0], ho);
        if (acc && (l != (part.size() == N - 1))) m_err = 1'b1;
        @(posedge clk);
        if (ho) begin
            void'(pend.pop_front());
            m_done++;
        end
        if (acc) begin
            part.push_back(p);
            if (part.size() == N) begin
                for (int i = 0; i < N; i++) t[i*32 +: 32] = part[i];
                pend.push_back(t);
                part.delete();
                made++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] p, input logic tr);
        cyc(1'b1, p, part.size() == N - 1, tr);
    endtask

    // Asserts reset in mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_ready", {63'b0, pix_ready}, 64'd1);
        check("rst_valid", {63'b0, tile_valid}, 64'd0);
        check("rst_err", {63'b0, frame_err}, 64'd0);
        check("rst_done", {60'b0, tiles_done}, 64'd0);
        check_tile("rst_tile", '0, 1'b0);
        part.delete(); pend.delete(); m_err = 1'b0; m_done = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tile_t a5;
        int cycles;
        for (int i = 0; i < N; i++) a5[i*32 +: 32] = 32'hA5;
        @(negedge clk);
        do_reset();

        // 1: single tile, consumer always ready
        for (int i = 0; i < N; i++) send(i, 1'b1);
        check("t1_valid", {63'b0, tile_valid}, 64'd1);
        check_tile("t1_tile", pend[0], 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("t1_done", {60'b0, tiles_done}, 64'd1);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // 2: three tiles with consumer stalled, then a single ready pulse
        for (int i = 0; i < 2 * N; i++) send(i, 1'b0);
        check("t2_stall", {63'b0, pix_ready}, 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'd999, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("t2_tile1", {32'b0, tile_out[0]}, 64'd64);
        check("t2_ready", {63'b0, pix_ready}, 64'd1);
        for (int i = 2 * N; i < 3 * N; i++) send(i, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b0, 1'b1);

        // 3: continuous stream, tile taken the cycle the next tile completes
        ready_seen_low = 1'b0;
        for (int i = 0; i < 5 * N; i++) send($urandom, part.size() == N - 1);
        check("t3_no_stall", {63'b0, ready_seen_low}, 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b1);

        // 4: spurious pix_last on pixel 10, tile still closes at 63
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, i, i == 10 || i == N - 1, 1'b0);
            if (i == 10) check("t4_err_set", {63'b0, frame_err}, 64'd1);
        end
        check("t4_closed", {63'b0, tile_valid}, 64'd1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("t4_sticky", {63'b0, frame_err}, 64'd1);

        // 5: reset mid-tile, then a full tile of 0xA5
        for (int i = 0; i < 30; i++) send(i, 1'b0);
        do_reset();
        for (int i = 0; i < N; i++) send(32'hA5, 1'b0);
        check_tile("t5_tile", a5, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // 6: random gaps on both sides, occasional framing error
        cycles = 0;
        made = 0;
        while (made < 300 && cycles < 60000) begin
            cyc($urandom_range(0, 7) != 0, $urandom,
                (part.size() == N - 1) ^ ($urandom_range(0, 999) == 0),
                $urandom_range(0, 2) == 0);
            cycles++;
        end
        check("t6_tiles", made, 300);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
